// File: rtl/sar_conversion_controller_pkg.sv
// Shared types and width helpers for the SAR conversion controller.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DECIDE = 2'd2
   } sar_state_e;

   // Settle counter holds 0 .. SETTLE_CYCLES-1; never narrower than one bit.
   function automatic int unsigned settle_cnt_width(input int unsigned settle_cycles);
      return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
   endfunction

   function automatic int unsigned bit_idx_width(input int unsigned n_bits);
      return (n_bits > 1) ? $clog2(n_bits) : 1;
   endfunction

endpackage

// File: rtl/sar_conversion_controller_if.sv
// Handshake, comparator and result signals of the SAR conversion controller.
interface sar_conversion_controller_if #(
   parameter int unsigned N_BITS = 8
);
   logic              start;
   logic              abort;
   logic              cmp_in;
   logic              cmp_strobe;
   logic [N_BITS-1:0] dac_code;
   logic              busy;
   logic              done;
   logic [N_BITS-1:0] result;
   logic              result_valid;

   modport master (
      output start, abort, cmp_in,
      input  cmp_strobe, dac_code, busy, done, result, result_valid
   );

   modport slave (
      input  start, abort, cmp_in,
      output cmp_strobe, dac_code, busy, done, result, result_valid
   );
endinterface

// File: rtl/sar_conversion_controller_settle_timer.sv
// Loadable down-counter that paces the DAC settle interval before each decision.
module sar_settle_timer #(
   parameter int unsigned CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);
endmodule

// File: rtl/sar_conversion_controller.sv
// Successive-approximation sequencer: binary-searches the comparator one bit per step.
module sar_conversion_controller
   import sar_pkg::*;
#(
   parameter int unsigned N_BITS        = 8,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   sar_conversion_controller_if.slave   bus
);
   localparam int unsigned CNT_W = settle_cnt_width(SETTLE_CYCLES);
   localparam int unsigned IDX_W = bit_idx_width(N_BITS);

   sar_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [N_BITS-1:0] dac_q, dac_d;
   logic [N_BITS-1:0] result_q, result_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              strobe_q, strobe_d;
   logic              valid_q, valid_d;

   logic              tmr_load;
   logic              tmr_zero;
   logic [N_BITS-1:0] decide_code;

   sar_settle_timer #(
      .CNT_W (CNT_W)
   ) u_settle_timer (
      .clk      (clk),
      .rst_n    (reset),
      .load     (tmr_load),
      .en       (state_q == SETTLE),
      .load_val (CNT_W'(SETTLE_CYCLES - 1)),
      .zero     (tmr_zero)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dac_d       = dac_q;
      result_d    = result_q;
      busy_d      = busy_q;
      valid_d     = valid_q;
      done_d      = 1'b0;
      strobe_d    = 1'b0;
      tmr_load    = 1'b0;
      // Trial bit already set; the comparator decides whether it stays.
      decide_code         = dac_q;
      decide_code[idx_q]  = bus.cmp_in;

      if (bus.abort && (state_q != IDLE)) begin
         state_d = IDLE;
         dac_d   = '0;
         busy_d  = 1'b0;
         valid_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  dac_d             = '0;
                  dac_d[N_BITS-1]   = 1'b1;
                  idx_d             = IDX_W'(N_BITS - 1);
                  tmr_load          = 1'b1;
                  busy_d            = 1'b1;
                  valid_d           = 1'b0;
                  state_d           = SETTLE;
               end
            end
            SETTLE: begin
               if (tmr_zero) begin
                  strobe_d = 1'b1;
                  state_d  = DECIDE;
               end
            end
            DECIDE: begin
               if (idx_q != '0) begin
                  dac_d                      = decide_code;
                  dac_d[idx_q - IDX_W'(1)]   = 1'b1;
                  idx_d                      = idx_q - IDX_W'(1);
                  tmr_load                   = 1'b1;
                  state_d                    = SETTLE;
               end else begin
                  dac_d    = decide_code;
                  result_d = decide_code;
                  done_d   = 1'b1;
                  valid_d  = 1'b1;
                  busy_d   = 1'b0;
                  state_d  = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         dac_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         strobe_q <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         dac_q    <= dac_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         strobe_q <= strobe_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.dac_code     = dac_q;
   assign bus.result       = result_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.cmp_strobe   = strobe_q;
   assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_sar_conversion_controller.sv
// Directed-vector bench for the SAR conversion controller (8-bit/S=2 and 4-bit/S=1).
module tb_sar_conversion_controller;
   logic       clk;
   logic       reset;
   logic [7:0] vin8;
   logic [3:0] vin4;
   int         nchk;
   int         nfail;

   int         lat;
   int         ndone;
   int         ns;
   logic [7:0] trace [8];
   logic       ab_busy;
   logic       ab_valid;
   logic [7:0] ab_dac;
   logic [7:0] ab_res;

   sar_conversion_controller_if #(.N_BITS(8)) bus8 ();
   sar_conversion_controller_if #(.N_BITS(4)) bus4 ();

   sar_conversion_controller #(.N_BITS(8), .SETTLE_CYCLES(2)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   sar_conversion_controller #(.N_BITS(4), .SETTLE_CYCLES(1)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   assign bus8.cmp_in = (vin8 >= bus8.dac_code);
   assign bus4.cmp_in = (vin4 >= bus4.dac_code);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One 8-bit conversion observed for 40 cycles after E0; optional abort and mid-run start pulses.
   task automatic conv8(input logic [7:0] v, input int abort_at, input int pulse_at);
      vin8       = v;
      bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      lat = -1; ndone = 0; ns = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus8.cmp_strobe) begin
            if (ns < 8) trace[ns] = bus8.dac_code;
            ns++;
         end
         if (bus8.done) begin
            ndone++;
            if (lat < 0) lat = c;
         end
         if (abort_at >= 0 && c == abort_at + 1) begin
            ab_busy  = bus8.busy;
            ab_valid = bus8.result_valid;
            ab_dac   = bus8.dac_code;
            ab_res   = bus8.result;
         end
         bus8.abort = (abort_at >= 0 && c == abort_at);
         bus8.start = (pulse_at >= 0 && (c == pulse_at || c == pulse_at + 7));
         step();
      end
      bus8.abort = 1'b0;
      bus8.start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      nchk++; if (bus8.dac_code !== 8'h00) begin nfail++; $display("FAIL reset_dac got=%h exp=00", bus8.dac_code); end
      nchk++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.cmp_strobe !== 1'b0) begin
         nfail++; $display("FAIL reset_flags busy=%b done=%b strobe=%b exp=000", bus8.busy, bus8.done, bus8.cmp_strobe); end
      nchk++; if (bus8.result !== 8'h00 || bus8.result_valid !== 1'b0) begin
         nfail++; $display("FAIL reset_result got=%h/%b exp=00/0", bus8.result, bus8.result_valid); end
      nchk++; if (bus4.dac_code !== 4'h0 || bus4.busy !== 1'b0) begin
         nfail++; $display("FAIL reset_dut4 dac=%h busy=%b exp=0/0", bus4.dac_code, bus4.busy); end
      #3 reset = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [7:0] exp_tr [8];
      exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
      conv8(8'hA5, -1, -1);
      nchk++; if (bus8.result !== 8'hA5) begin nfail++; $display("FAIL basic_result got=%h exp=a5", bus8.result); end
      nchk++; if (lat !== 24) begin nfail++; $display("FAIL basic_latency got=%0d exp=24", lat); end
      nchk++; if (ndone !== 1) begin nfail++; $display("FAIL basic_done_count got=%0d exp=1", ndone); end
      nchk++; if (ns !== 8) begin nfail++; $display("FAIL basic_strobes got=%0d exp=8", ns); end
      for (int i = 0; i < 8; i++) begin
         nchk++;
         if (trace[i] !== exp_tr[i]) begin nfail++; $display("FAIL basic_trace[%0d] got=%h exp=%h", i, trace[i], exp_tr[i]); end
      end
      nchk++; if (bus8.result_valid !== 1'b1 || bus8.busy !== 1'b0) begin
         nfail++; $display("FAIL basic_final valid=%b busy=%b exp=1/0", bus8.result_valid, bus8.busy); end
   endtask

   task automatic test_boundary();
      conv8(8'h00, -1, -1);
      nchk++; if (bus8.result !== 8'h00) begin nfail++; $display("FAIL zero_result got=%h exp=00", bus8.result); end
      nchk++; if (ns !== 8) begin nfail++; $display("FAIL zero_strobes got=%0d exp=8", ns); end
      nchk++; if (trace[7] !== 8'h01) begin nfail++; $display("FAIL zero_last_trial got=%h exp=01", trace[7]); end
      conv8(8'hFF, -1, -1);
      nchk++; if (bus8.result !== 8'hFF) begin nfail++; $display("FAIL full_result got=%h exp=ff", bus8.result); end
      nchk++; if (ns !== 8) begin nfail++; $display("FAIL full_strobes got=%0d exp=8", ns); end
   endtask

   task automatic test_start_ignored();
      conv8(8'h3C, -1, 5);
      nchk++; if (bus8.result !== 8'h3C) begin nfail++; $display("FAIL ignore_result got=%h exp=3c", bus8.result); end
      nchk++; if (lat !== 24) begin nfail++; $display("FAIL ignore_latency got=%0d exp=24", lat); end
      nchk++; if (ndone !== 1) begin nfail++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
   endtask

   task automatic test_back_to_back();
      int d1, d2, nd;
      d1 = -1; d2 = -1; nd = 0;
      vin8       = 8'h5A;
      bus8.start = 1'b1;
      step();
      for (int c = 0; c < 55; c++) begin
         if (bus8.done) begin
            nd++;
            if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
         end
         if (c == 25) begin
            nchk++; if (bus8.busy !== 1'b1 || bus8.result_valid !== 1'b0) begin
               nfail++; $display("FAIL b2b_restart busy=%b valid=%b exp=1/0", bus8.busy, bus8.result_valid); end
            bus8.start = 1'b0;
         end
         step();
      end
      nchk++; if (nd !== 2) begin nfail++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
      nchk++; if (d1 !== 24 || d2 !== 49) begin nfail++; $display("FAIL b2b_done_cycles got=%0d,%0d exp=24,49", d1, d2); end
      nchk++; if (bus8.result !== 8'h5A) begin nfail++; $display("FAIL b2b_result got=%h exp=5a", bus8.result); end
   endtask

   task automatic test_abort();
      conv8(8'hC3, 10, -1);
      nchk++; if (ab_busy !== 1'b0 || ab_valid !== 1'b0) begin
         nfail++; $display("FAIL abort_flags busy=%b valid=%b exp=0/0", ab_busy, ab_valid); end
      nchk++; if (ab_dac !== 8'h00) begin nfail++; $display("FAIL abort_dac got=%h exp=00", ab_dac); end
      nchk++; if (ab_res !== 8'h5A) begin nfail++; $display("FAIL abort_result got=%h exp=5a", ab_res); end
      nchk++; if (ndone !== 0) begin nfail++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
      conv8(8'h11, 23, -1);
      nchk++; if (ndone !== 0) begin nfail++; $display("FAIL abort_last_no_done got=%0d exp=0", ndone); end
      nchk++; if (ab_busy !== 1'b0 || ab_res !== 8'h5A || bus8.result !== 8'h5A) begin
         nfail++; $display("FAIL abort_last_state busy=%b res=%h final=%h exp=0/5a/5a", ab_busy, ab_res, bus8.result); end
   endtask

   task automatic test_reset_mid();
      vin8       = 8'h33;
      bus8.start = 1'b1;
      step();
      bus8.start = 1'b0;
      for (int c = 0; c < 4; c++) step();
      #2 reset = 1'b0;
      #1;
      nchk++; if (bus8.busy !== 1'b0 || bus8.dac_code !== 8'h00) begin
         nfail++; $display("FAIL rstmid_async busy=%b dac=%h exp=0/00", bus8.busy, bus8.dac_code); end
      nchk++; if (bus8.result !== 8'h00 || bus8.result_valid !== 1'b0 || bus8.cmp_strobe !== 1'b0) begin
         nfail++; $display("FAIL rstmid_result res=%h valid=%b strobe=%b exp=00/0/0", bus8.result, bus8.result_valid, bus8.cmp_strobe); end
      #3 reset = 1'b1;
      step();
      conv8(8'h77, -1, -1);
      nchk++; if (bus8.result !== 8'h77 || lat !== 24) begin
         nfail++; $display("FAIL rstmid_reconvert res=%h lat=%0d exp=77/24", bus8.result, lat); end
   endtask

   task automatic test_small();
      int l4, nd4, ns4;
      l4 = -1; nd4 = 0; ns4 = 0;
      vin4       = 4'h9;
      bus4.start = 1'b1;
      step();
      bus4.start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus4.cmp_strobe) ns4++;
         if (bus4.done) begin
            nd4++;
            if (l4 < 0) l4 = c;
         end
         step();
      end
      nchk++; if (bus4.result !== 4'h9) begin nfail++; $display("FAIL small_result got=%h exp=9", bus4.result); end
      nchk++; if (l4 !== 8) begin nfail++; $display("FAIL small_latency got=%0d exp=8", l4); end
      nchk++; if (nd4 !== 1 || ns4 !== 4) begin nfail++; $display("FAIL small_counts done=%0d strobes=%0d exp=1/4", nd4, ns4); end
   endtask

   initial begin
      nchk = 0; nfail = 0;
      vin8 = 8'h00; vin4 = 4'h0;
      bus8.start = 1'b0; bus8.abort = 1'b0;
      bus4.start = 1'b0; bus4.abort = 1'b0;
      test_reset();
      test_basic();
      test_boundary();
      test_start_ignored();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_small();
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end
endmodule
